// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: shares one Avalon-MM SDRAM slave between two requesters,
// tagging accepted reads so returning beats are routed back to their issuer.
module sdram_port_arbiter #(
  parameter int ADDR_W   = 25,
  parameter int DATA_W   = 16,
  parameter int MAX_PEND = 4,
  parameter int HOLD_MAX = 8
) (
  input  logic                          clk_clk,
  input  logic                          reset_reset_n,
  input  logic [ADDR_W-1:0]             p0_address,
  input  logic                          p0_read,
  input  logic                          p0_write,
  input  logic [DATA_W-1:0]             p0_writedata,
  input  logic [DATA_W/8-1:0]           p0_byteenable,
  output logic                          p0_waitrequest,
  output logic [DATA_W-1:0]             p0_readdata,
  output logic                          p0_readdatavalid,
  input  logic [ADDR_W-1:0]             p1_address,
  input  logic                          p1_read,
  input  logic                          p1_write,
  input  logic [DATA_W-1:0]             p1_writedata,
  input  logic [DATA_W/8-1:0]           p1_byteenable,
  output logic                          p1_waitrequest,
  output logic [DATA_W-1:0]             p1_readdata,
  output logic                          p1_readdatavalid,
  output logic [ADDR_W-1:0]             m_address,
  output logic                          m_read,
  output logic                          m_write,
  output logic [DATA_W-1:0]             m_writedata,
  output logic [DATA_W/8-1:0]           m_byteenable,
  input  logic                          m_waitrequest,
  input  logic [DATA_W-1:0]             m_readdata,
  input  logic                          m_readdatavalid,
  output logic [$clog2(MAX_PEND):0]     pend_cnt,
  output logic                          err_orphan
);
  localparam int PW = $clog2(MAX_PEND);
  localparam int HW = $clog2(HOLD_MAX) + 1;
  typedef enum logic {IDLE, BUSY} state_t;
  state_t st, st_n;
  logic g, g_n;
  logic [HW-1:0] hold_cnt, hold_n;
  logic [PW:0] wp, rp;
  logic [MAX_PEND-1:0] tags;
  logic [DATA_W-1:0] rdata;
  logic busy, rd_g, wr_g, req_o, empty, full, full_eff, wq_g, acc, push, pop, hold_sat;
  assign busy  = st == BUSY;
  assign rd_g  = g ? p1_read : p0_read;
  assign wr_g  = g ? p1_write : p0_write;
  assign req_o = g ? (p0_read | p0_write) : (p1_read | p1_write);
  assign empty = wp == rp;
  assign full  = (wp[PW] != rp[PW]) && (wp[PW-1:0] == rp[PW-1:0]);
  // a beat returning this cycle frees a slot, so a blocked read can go in alongside the pop
  assign full_eff = full & ~m_readdatavalid;
  assign m_address    = g ? p1_address : p0_address;
  assign m_writedata  = g ? p1_writedata : p0_writedata;
  assign m_byteenable = g ? p1_byteenable : p0_byteenable;
  assign m_write = busy & wr_g;
  assign m_read  = busy & rd_g & ~wr_g & ~full_eff;
  assign wq_g    = m_waitrequest | (rd_g & ~wr_g & full_eff);
  assign p0_waitrequest = ~busy | g | wq_g;
  assign p1_waitrequest = ~busy | ~g | wq_g;
  assign acc  = (m_read | m_write) & ~m_waitrequest;
  assign push = m_read & ~m_waitrequest;
  assign pop  = m_readdatavalid & ~empty;
  assign pend_cnt = wp - rp;
  assign p0_readdata = rdata;
  assign p1_readdata = rdata;
  // hold_cnt saturates so a late-arriving competitor still forces the switch on the next accept
  assign hold_sat = hold_cnt == HW'(HOLD_MAX - 1);
  always_comb begin
    st_n = st;
    g_n = g;
    hold_n = hold_cnt;
    if (!busy) begin
      st_n = (p0_read | p0_write | p1_read | p1_write) ? BUSY : IDLE;
      g_n = ~(p0_read | p0_write) & (p1_read | p1_write);
      hold_n = '0;
    end else if (!(rd_g | wr_g)) begin
      st_n = IDLE;
    end else if (acc) begin
      g_n = (hold_sat & req_o) ? ~g : g;
      hold_n = hold_sat ? (req_o ? '0 : hold_cnt) : hold_cnt + 1'b1;
    end
  end
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      st <= IDLE;
      g <= 1'b0;
      hold_cnt <= '0;
      wp <= '0;
      rp <= '0;
      tags <= '0;
      rdata <= '0;
      p0_readdatavalid <= 1'b0;
      p1_readdatavalid <= 1'b0;
      err_orphan <= 1'b0;
    end else begin
      st <= st_n;
      g <= g_n;
      hold_cnt <= hold_n;
      if (push) tags[wp[PW-1:0]] <= g;
      if (push) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      if (m_readdatavalid) rdata <= m_readdata;
      p0_readdatavalid <= pop & ~tags[rp[PW-1:0]];
      p1_readdatavalid <= pop & tags[rp[PW-1:0]];
      err_orphan <= err_orphan | (m_readdatavalid & empty);
    end
  end
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// tb_sdram_port_arbiter: directed table and corner sequences, then random traffic
// checked against a transaction-level model of grants, tags and returns.
module tb_sdram_port_arbiter;
  localparam int AW = 25, DW = 16, BW = 2, MP = 4, HM = 8;
  logic clk_clk = 1'b0, reset_reset_n = 1'b0;
  logic [AW-1:0] p0_address, p1_address, m_address;
  logic p0_read, p0_write, p1_read, p1_write, m_read, m_write;
  logic [DW-1:0] p0_writedata, p1_writedata, m_writedata, p0_readdata, p1_readdata, m_readdata;
  logic [BW-1:0] p0_byteenable, p1_byteenable, m_byteenable;
  logic p0_waitrequest, p1_waitrequest, p0_readdatavalid, p1_readdatavalid;
  logic m_waitrequest, m_readdatavalid, err_orphan;
  logic [2:0] pend_cnt;
  int pass_cnt = 0, total = 0;

  sdram_port_arbiter dut (
    .clk_clk(clk_clk), .reset_reset_n(reset_reset_n),
    .p0_address(p0_address), .p0_read(p0_read), .p0_write(p0_write),
    .p0_writedata(p0_writedata), .p0_byteenable(p0_byteenable),
    .p0_waitrequest(p0_waitrequest), .p0_readdata(p0_readdata), .p0_readdatavalid(p0_readdatavalid),
    .p1_address(p1_address), .p1_read(p1_read), .p1_write(p1_write),
    .p1_writedata(p1_writedata), .p1_byteenable(p1_byteenable),
    .p1_waitrequest(p1_waitrequest), .p1_readdata(p1_readdata), .p1_readdatavalid(p1_readdatavalid),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata), .m_readdatavalid(m_readdatavalid),
    .pend_cnt(pend_cnt), .err_orphan(err_orphan)
  );

  always #5 clk_clk = ~clk_clk;

  typedef struct packed {
    logic r0, r1, mv;
    logic [15:0] md;
    logic mr;
    logic [24:0] ma;
    logic wq0, wq1, v0, v1;
    logic [15:0] rd;
    logic [2:0] pc;
  } vec_t;
  vec_t tbl [8];

  logic [1:0] act, isw;
  logic [AW-1:0] addr [2];
  logic [DW-1:0] wd [2];
  logic [BW-1:0] be [2];
  logic q [$];
  int oth_acc [2];
  logic exp_v, exp_p;
  logic [DW-1:0] exp_d;

  task automatic chk(input string name, input logic [63:0] act_v, input logic [63:0] exp_v_);
    total++;
    if (act_v === exp_v_) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act_v, exp_v_);
  endtask

  task automatic nxt();
    @(posedge clk_clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk_clk);
  endtask

  task automatic idle_in();
    {p0_read, p0_write, p1_read, p1_write} = '0;
    p0_address = '0; p1_address = '0;
    p0_writedata = '0; p1_writedata = '0;
    p0_byteenable = '1; p1_byteenable = '1;
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
  endtask

  task automatic do_reset();
    idle_in();
    reset_reset_n = 1'b0;
    nxt();
    nxt();
    reset_reset_n = 1'b1;
  endtask

  task automatic drive();
    p0_read = act[0] & ~isw[0]; p0_write = act[0] & isw[0];
    p1_read = act[1] & ~isw[1]; p1_write = act[1] & isw[1];
    p0_address = addr[0]; p1_address = addr[1];
    p0_writedata = wd[0]; p1_writedata = wd[1];
    p0_byteenable = be[0]; p1_byteenable = be[1];
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b0, 16'h0,    1'b0, 25'h0,   1'b1, 1'b1, 1'b0, 1'b0, 16'h0,    3'd0};
    tbl[1] = '{1'b1, 1'b1, 1'b0, 16'h0,    1'b1, 25'h100, 1'b0, 1'b1, 1'b0, 1'b0, 16'h0,    3'd0};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 16'h0,    1'b0, 25'h0,   1'b0, 1'b1, 1'b0, 1'b0, 16'h0,    3'd1};
    tbl[3] = '{1'b0, 1'b1, 1'b1, 16'hAAAA, 1'b0, 25'h0,   1'b1, 1'b1, 1'b0, 1'b0, 16'h0,    3'd1};
    tbl[4] = '{1'b0, 1'b1, 1'b0, 16'h0,    1'b1, 25'h200, 1'b1, 1'b0, 1'b1, 1'b0, 16'hAAAA, 3'd0};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 16'h5555, 1'b0, 25'h0,   1'b1, 1'b0, 1'b0, 1'b0, 16'h0,    3'd1};
    tbl[6] = '{1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 25'h0,   1'b1, 1'b1, 1'b0, 1'b1, 16'h5555, 3'd0};
    tbl[7] = '{1'b0, 1'b0, 1'b0, 16'h0,    1'b0, 25'h0,   1'b1, 1'b1, 1'b0, 1'b0, 16'h0,    3'd0};

    // reset held with both ports requesting
    idle_in();
    p0_read = 1'b1; p1_write = 1'b1;
    nxt();
    nxt();
    mid();
    chk("reset_state",
        {m_read, m_write, p0_waitrequest, p1_waitrequest, pend_cnt, err_orphan,
         p0_readdatavalid, p1_readdatavalid, p0_readdata, p1_readdata},
        {1'b0, 1'b0, 1'b1, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0, 16'h0, 16'h0});
    nxt();
    reset_reset_n = 1'b1;
    p1_write = 1'b0;
    p0_address = 25'h100; p1_address = 25'h200;

    // simultaneous single reads, table-driven
    for (int i = 0; i < 8; i++) begin
      p0_read = tbl[i].r0; p1_read = tbl[i].r1;
      m_readdatavalid = tbl[i].mv; m_readdata = tbl[i].md;
      mid();
      chk($sformatf("vec%0d", i),
          {m_read, m_write, m_read ? m_address : 25'h0, p0_waitrequest, p1_waitrequest,
           p0_readdatavalid, p1_readdatavalid,
           (p0_readdatavalid | p1_readdatavalid) ? p0_readdata : 16'h0, pend_cnt},
          {tbl[i].mr, 1'b0, tbl[i].ma, tbl[i].wq0, tbl[i].wq1, tbl[i].v0, tbl[i].v1, tbl[i].rd, tbl[i].pc});
      nxt();
    end

    // fairness: both ports writing continuously
    do_reset();
    p0_write = 1'b1; p1_write = 1'b1;
    p0_address = 25'h11; p1_address = 25'h22;
    for (int k = 0; k < 34; k++) begin
      mid();
      if (k == 0) chk("fair_bubble", m_write, 1'b0);
      else chk($sformatf("fair%0d", k), {m_write, m_waitrequest, m_address},
               {1'b1, 1'b0, (((k - 1) / HM) % 2 == 1) ? 25'h22 : 25'h11});
      nxt();
    end

    // FIFO full: p1 issues five reads with no returns
    do_reset();
    p1_read = 1'b1; p1_address = 25'h300;
    mid();
    chk("full_idle_wq", p1_waitrequest, 1'b1);
    nxt();
    for (int k = 0; k < MP; k++) begin
      mid();
      chk($sformatf("full_acc%0d", k), {m_read, p1_waitrequest}, 2'b10);
      nxt();
      p1_address = p1_address + 25'h1;
    end
    for (int k = 0; k < 3; k++) begin
      mid();
      chk($sformatf("full_block%0d", k), {m_read, p1_waitrequest, pend_cnt}, {1'b0, 1'b1, 3'd4});
      nxt();
    end
    m_readdatavalid = 1'b1; m_readdata = 16'h1234;
    mid();
    chk("full_pop_accept", {m_read, p1_waitrequest, m_address}, {1'b1, 1'b0, 25'h304});
    nxt();
    m_readdatavalid = 1'b0; p1_read = 1'b0;
    mid();
    chk("full_after_pop", {pend_cnt, p1_readdatavalid, p0_readdatavalid, p1_readdata},
        {3'd4, 1'b1, 1'b0, 16'h1234});

    // orphan beat, then reset with reads pending
    do_reset();
    m_readdatavalid = 1'b1; m_readdata = 16'hBEEF;
    nxt();
    m_readdatavalid = 1'b0;
    mid();
    chk("orphan", {err_orphan, p0_readdatavalid, p1_readdatavalid}, 3'b100);
    nxt();
    p0_read = 1'b1;
    repeat (4) begin
      nxt();
      p0_address = p0_address + 25'h1;
    end
    p0_read = 1'b0;
    mid();
    chk("pend3", {pend_cnt, err_orphan}, {3'd3, 1'b1});
    #1 reset_reset_n = 1'b0;
    #1 chk("async_reset", {pend_cnt, err_orphan, p0_waitrequest, p1_waitrequest, m_read},
           {3'd0, 1'b0, 1'b1, 1'b1, 1'b0});

    // randomized traffic against the transaction model
    do_reset();
    act = '0; isw = '0;
    for (int p = 0; p < 2; p++) begin
      addr[p] = '0; wd[p] = '0; be[p] = '0; oth_acc[p] = 0;
    end
    exp_v = 1'b0; exp_p = 1'b0; exp_d = '0;
    drive();
    for (int i = 0; i < 3000; i++) begin
      logic a0, a1, macc, n;
      logic [1:0] accv;
      mid();
      chk("r_pend", pend_cnt, q.size());
      chk("r_valid", {p0_readdatavalid, p1_readdatavalid}, {exp_v & ~exp_p, exp_v & exp_p});
      if (exp_v) chk("r_data", exp_p ? p1_readdata : p0_readdata, exp_d);
      a0 = act[0] & ~p0_waitrequest;
      a1 = act[1] & ~p1_waitrequest;
      macc = (m_read | m_write) & ~m_waitrequest;
      chk("r_accept", {a0 & a1, a0 | a1}, {1'b0, macc});
      n = a1;
      if (a0 | a1)
        chk("r_cmd", {m_address, m_write, m_read, m_byteenable, m_write ? m_writedata : 16'h0},
            {addr[n], isw[n], ~isw[n], be[n], isw[n] ? wd[n] : 16'h0});
      chk("r_no_overflow", (a0 | a1) & ~isw[n] & (q.size() >= MP) & ~m_readdatavalid, 1'b0);
      accv = {a1, a0};
      for (int p = 0; p < 2; p++) begin
        if (!act[1 - p] || accv[p]) oth_acc[p] = 0;
        else if (act[p] && accv[1 - p]) oth_acc[p]++;
        chk("r_starve", oth_acc[p] <= HM, 1'b1);
      end
      chk("r_orphan", err_orphan, 1'b0);
      exp_v = m_readdatavalid;
      if (m_readdatavalid) begin
        exp_p = q.pop_front();
        exp_d = m_readdata;
      end
      nxt();
      if ((a0 | a1) && !isw[n]) q.push_back(n);
      for (int p = 0; p < 2; p++) begin
        if (accv[p] || !act[p]) begin
          act[p] = ($urandom % 4) != 0;
          isw[p] = $urandom % 2;
          addr[p] = AW'($urandom);
          wd[p] = DW'($urandom);
          be[p] = BW'($urandom);
        end
      end
      drive();
      m_waitrequest = ($urandom % 4) == 0;
      m_readdatavalid = (q.size() > 0) && (($urandom % ((i < 1500) ? 6 : 2)) == 0);
      m_readdata = DW'($urandom);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule
